process_scheduler: RTL and testbench

//   Round-robin process table on the OS side of the PC context-change interface.
//   - Consumes the PC's context-change pulse, saved line and end-of-process flag.
//   - Saves the preempted PC and selects the next ready process.
//   - Returns resume address and quantum to the PC through a valid/ready grant handshake.
//   - Sits between the PC and the OS control logic that loads processes.

---
 rtl/sched_pkg.sv | 24 ++
 rtl/sched_proc_table.sv | 69 ++++++
 rtl/process_scheduler.sv | 254 +++++++++++++++++++++++++
 tb/tb_process_scheduler.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// ---------------------------------------------------------------------------
// sched_pkg
//   Shared types and constants for the process scheduler block.
//   - state_e : scheduler FSM states
//   - CNT_W   : width of the optional per-slot dispatch counters
//   - slot_w(): slot index width for a given number of process slots
// ---------------------------------------------------------------------------
package sched_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SEARCH = 3'd1,
        GRANT  = 3'd2,
        RUN    = 3'd3,
        SAVE   = 3'd4
    } state_e;

    localparam int unsigned CNT_W = 16;

    function automatic int unsigned slot_w(input int unsigned n);
        return (n > 32'd1) ? $clog2(n) : 32'd1;
    endfunction

endpackage

// File: rtl/sched_proc_table.sv
// ---------------------------------------------------------------------------
// sched_proc_table
//   NPROC-entry process table: start/resume PC, quantum and valid bit per slot.
//   Load and save write ports; a load to the same slot as a save wins and the
//   save (including its valid-clear) is dropped. One asynchronous read port.
//
// Ports
//   i_clk, i_rst_n                     clock, async active-low reset (clears table)
//   i_load_en/_slot/_pc/_quantum       OS load: writes pc, quantum, valid=1
//   i_save_en/_slot/_pc/_clr           context save: writes pc, optionally clears valid
//   i_rd_slot                          read address
//   o_rd_pc/_quantum/_valid            combinational read data
// ---------------------------------------------------------------------------
module sched_proc_table
    import sched_pkg::*;
#(
    parameter  int unsigned NPROC  = 4,
    parameter  int unsigned AW     = 32,
    parameter  int unsigned QW     = 32,
    localparam int unsigned SLOT_W = slot_w(NPROC)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_load_en,
    input  logic [SLOT_W-1:0] i_load_slot,
    input  logic [AW-1:0]     i_load_pc,
    input  logic [QW-1:0]     i_load_quantum,
    input  logic              i_save_en,
    input  logic [SLOT_W-1:0] i_save_slot,
    input  logic [AW-1:0]     i_save_pc,
    input  logic              i_save_clr,
    input  logic [SLOT_W-1:0] i_rd_slot,
    output logic [AW-1:0]     o_rd_pc,
    output logic [QW-1:0]     o_rd_quantum,
    output logic              o_rd_valid
);

    logic [AW-1:0]    r_pc      [NPROC];
    logic [QW-1:0]    r_quantum [NPROC];
    logic [NPROC-1:0] r_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < NPROC; i++) begin
                r_pc[i]      <= '0;
                r_quantum[i] <= '0;
            end
            r_valid <= '0;
        end else begin
            for (int unsigned i = 0; i < NPROC; i++) begin
                if (i_load_en && (i_load_slot == SLOT_W'(i))) begin
                    r_pc[i]      <= i_load_pc;
                    r_quantum[i] <= i_load_quantum;
                    r_valid[i]   <= 1'b1;
                end else if (i_save_en && (i_save_slot == SLOT_W'(i))) begin
                    r_pc[i] <= i_save_pc;
                    if (i_save_clr) begin
                        r_valid[i] <= 1'b0;
                    end
                end
            end
        end
    end

    assign o_rd_pc      = r_pc[i_rd_slot];
    assign o_rd_quantum = r_quantum[i_rd_slot];
    assign o_rd_valid   = r_valid[i_rd_slot];

endmodule

// File: rtl/process_scheduler.sv
// ---------------------------------------------------------------------------
// process_scheduler
//   Round-robin process table on the OS side of the PC context-change
//   interface. Saves the preempted PC on a context-change event, searches the
//   table one slot per cycle starting after the last dispatched slot, and
//   offers the next ready process to the PC through a valid/ready grant.
//
// Ports
//   CLK, reset                  clock (rising edge), async active-low reset
//   ctx_req                     context-change level; rising edge = switch event
//   saved_pc, proc_end          sampled on ctx_req rise while running
//   sched_req                   OS pulse: dispatch next ready process (IDLE only)
//   load_en/_slot/_pc/_quantum  OS writes a slot (any state)
//   grant_valid/_ready          grant handshake
//   grant_pc/_quantum/_slot     registered grant payload, stable while valid
//   active_slot, running        currently dispatched slot
//   none_ready                  one-cycle pulse: full search found nothing
//
// Configuration
//   SCHED_DISPATCH_CNT_EN       adds per-slot 16-bit saturating dispatch
//                               counters, read via stat_slot -> stat_count
// ---------------------------------------------------------------------------
module process_scheduler
    import sched_pkg::*;
#(
    parameter int unsigned NPROC = 4,
    parameter int unsigned AW    = 32,
    parameter int unsigned QW    = 32
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     ctx_req,
    input  logic [AW-1:0]            saved_pc,
    input  logic                     proc_end,
    input  logic                     sched_req,
    input  logic                     load_en,
    input  logic [$clog2(NPROC)-1:0] load_slot,
    input  logic [AW-1:0]            load_pc,
    input  logic [QW-1:0]            load_quantum,
    output logic                     grant_valid,
    input  logic                     grant_ready,
    output logic [AW-1:0]            grant_pc,
    output logic [QW-1:0]            grant_quantum,
    output logic [$clog2(NPROC)-1:0] grant_slot,
    output logic [$clog2(NPROC)-1:0] active_slot,
    output logic                     running,
    output logic                     none_ready
`ifdef SCHED_DISPATCH_CNT_EN
    ,
    input  logic [$clog2(NPROC)-1:0] stat_slot,
    output logic [CNT_W-1:0]         stat_count
`endif
);

    localparam int unsigned SLOT_W = slot_w(NPROC);
    localparam logic [SLOT_W-1:0] LAST_PROBE = SLOT_W'(NPROC - 1);

    state_e r_state;
    state_e w_state_nxt;

    logic [SLOT_W-1:0] r_idx;
    logic [SLOT_W-1:0] r_count;
    logic [SLOT_W-1:0] r_last_slot;
    logic [SLOT_W-1:0] r_active_slot;
    logic              r_running;
    logic              r_grant_valid;
    logic [AW-1:0]     r_grant_pc;
    logic [QW-1:0]     r_grant_quantum;
    logic [SLOT_W-1:0] r_grant_slot;
    logic              r_none_ready;
    logic              r_ctx_req_q;
    logic [AW-1:0]     r_saved_pc;
    logic              r_proc_end;

    logic              w_ctx_rise;
    logic              w_start;
    logic              w_hit;
    logic              w_miss_step;
    logic              w_miss_end;
    logic              w_accept;
    logic              w_ctx_evt;
    logic              w_save;

    logic [AW-1:0]     w_rd_pc;
    logic [QW-1:0]     w_rd_quantum;
    logic              w_rd_valid;

    sched_proc_table #(
        .NPROC (NPROC),
        .AW    (AW),
        .QW    (QW)
    ) u_table (
        .i_clk          (CLK),
        .i_rst_n        (reset),
        .i_load_en      (load_en),
        .i_load_slot    (load_slot),
        .i_load_pc      (load_pc),
        .i_load_quantum (load_quantum),
        .i_save_en      (w_save),
        .i_save_slot    (r_active_slot),
        .i_save_pc      (r_saved_pc),
        .i_save_clr     (r_proc_end),
        .i_rd_slot      (r_idx),
        .o_rd_pc        (w_rd_pc),
        .o_rd_quantum   (w_rd_quantum),
        .o_rd_valid     (w_rd_valid)
    );

    assign w_ctx_rise = ctx_req & ~r_ctx_req_q;

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_hit       = 1'b0;
        w_miss_step = 1'b0;
        w_miss_end  = 1'b0;
        w_accept    = 1'b0;
        w_ctx_evt   = 1'b0;
        w_save      = 1'b0;
        case (r_state)
            IDLE: begin
                if (sched_req) begin
                    w_start     = 1'b1;
                    w_state_nxt = SEARCH;
                end
            end
            SEARCH: begin
                if (w_rd_valid) begin
                    w_hit       = 1'b1;
                    w_state_nxt = GRANT;
                end else if (r_count == LAST_PROBE) begin
                    w_miss_end  = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_miss_step = 1'b1;
                end
            end
            GRANT: begin
                if (r_grant_valid && grant_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                if (w_ctx_rise) begin
                    w_ctx_evt   = 1'b1;
                    w_state_nxt = SAVE;
                end
            end
            SAVE: begin
                w_save      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_idx           <= '0;
            r_count         <= '0;
            r_last_slot     <= LAST_PROBE;
            r_active_slot   <= '0;
            r_running       <= 1'b0;
            r_grant_valid   <= 1'b0;
            r_grant_pc      <= '0;
            r_grant_quantum <= '0;
            r_grant_slot    <= '0;
            r_none_ready    <= 1'b0;
            r_ctx_req_q     <= 1'b0;
            r_saved_pc      <= '0;
            r_proc_end      <= 1'b0;
        end else begin
            r_ctx_req_q  <= ctx_req;
            r_none_ready <= w_miss_end;

            // Search starts just after the last dispatched slot; index wraps
            // by truncation so the last dispatched slot is the final probe.
            if (w_start) begin
                r_idx   <= r_last_slot + SLOT_W'(1);
                r_count <= '0;
            end
            if (w_miss_step) begin
                r_idx   <= r_idx + SLOT_W'(1);
                r_count <= r_count + SLOT_W'(1);
            end

            // Grant payload is captured once, so later loads to the same slot
            // cannot disturb an outstanding grant.
            if (w_hit) begin
                r_grant_valid   <= 1'b1;
                r_grant_pc      <= w_rd_pc;
                r_grant_quantum <= w_rd_quantum;
                r_grant_slot    <= r_idx;
            end
            if (w_accept) begin
                r_grant_valid <= 1'b0;
                r_active_slot <= r_grant_slot;
                r_last_slot   <= r_grant_slot;
                r_running     <= 1'b1;
            end

            if (w_ctx_evt) begin
                r_saved_pc <= saved_pc;
                r_proc_end <= proc_end;
            end
            if (w_save) begin
                r_running <= 1'b0;
            end
        end
    end

    assign grant_valid   = r_grant_valid;
    assign grant_pc      = r_grant_pc;
    assign grant_quantum = r_grant_quantum;
    assign grant_slot    = r_grant_slot;
    assign active_slot   = r_active_slot;
    assign running       = r_running;
    assign none_ready    = r_none_ready;

`ifdef SCHED_DISPATCH_CNT_EN
    logic [CNT_W-1:0] r_disp_cnt [NPROC];

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NPROC; i++) begin
                r_disp_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NPROC; i++) begin
                if (load_en && (load_slot == SLOT_W'(i))) begin
                    r_disp_cnt[i] <= '0;
                end else if (w_accept && (r_grant_slot == SLOT_W'(i)) &&
                             (r_disp_cnt[i] != '1)) begin
                    r_disp_cnt[i] <= r_disp_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign stat_count = r_disp_cnt[stat_slot];
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// ---------------------------------------------------------------------------
// tb_process_scheduler
//   Directed scenarios with literal expectations, followed by randomized
//   traffic. A queue-based reference model tracks the process table and the
//   scheduler phase; one compare process checks the outputs every cycle.
// ---------------------------------------------------------------------------
module tb_process_scheduler;

    localparam int unsigned NPROC = 4;
    localparam int unsigned AW    = 32;
    localparam int unsigned QW    = 32;
    localparam int unsigned SW    = 2;

    logic          CLK = 1'b0;
    logic          reset;
    logic          ctx_req;
    logic [AW-1:0] saved_pc;
    logic          proc_end;
    logic          sched_req;
    logic          load_en;
    logic [SW-1:0] load_slot;
    logic [AW-1:0] load_pc;
    logic [QW-1:0] load_quantum;
    logic          grant_valid;
    logic          grant_ready;
    logic [AW-1:0] grant_pc;
    logic [QW-1:0] grant_quantum;
    logic [SW-1:0] grant_slot;
    logic [SW-1:0] active_slot;
    logic          running;
    logic          none_ready;
`ifdef SCHED_DISPATCH_CNT_EN
    logic [SW-1:0] stat_slot = '0;
    logic [15:0]   stat_count;
`endif

    always #5 CLK = ~CLK;

    process_scheduler #(
        .NPROC (NPROC),
        .AW    (AW),
        .QW    (QW)
    ) dut (
        .CLK           (CLK),
        .reset         (reset),
        .ctx_req       (ctx_req),
        .saved_pc      (saved_pc),
        .proc_end      (proc_end),
        .sched_req     (sched_req),
        .load_en       (load_en),
        .load_slot     (load_slot),
        .load_pc       (load_pc),
        .load_quantum  (load_quantum),
        .grant_valid   (grant_valid),
        .grant_ready   (grant_ready),
        .grant_pc      (grant_pc),
        .grant_quantum (grant_quantum),
        .grant_slot    (grant_slot),
        .active_slot   (active_slot),
        .running       (running),
        .none_ready    (none_ready)
`ifdef SCHED_DISPATCH_CNT_EN
        ,
        .stat_slot     (stat_slot),
        .stat_count    (stat_count)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum int {PH_IDLE, PH_SEARCH, PH_GRANT, PH_RUN, PH_SAVE} phase_t;

    bit            m_valid [NPROC];
    logic [AW-1:0] m_pc    [NPROC];
    logic [QW-1:0] m_q     [NPROC];
    int            m_last;
    phase_t        m_phase;
    int            m_probes[$];
    bit            m_ctx_prev;
    logic [AW-1:0] m_spc;
    bit            m_end;
    bit            e_gv;
    logic [AW-1:0] e_gpc;
    logic [QW-1:0] e_gq;
    int            e_gslot;
    int            e_active;
    bit            e_running;
    bit            e_none;
    int            p_slot;
    bit            p_save;

    task automatic model_reset();
        for (int i = 0; i < NPROC; i++) begin
            m_valid[i] = 1'b0;
            m_pc[i]    = '0;
            m_q[i]     = '0;
        end
        m_last     = NPROC - 1;
        m_phase    = PH_IDLE;
        m_probes.delete();
        m_ctx_prev = 1'b0;
        m_spc      = '0;
        m_end      = 1'b0;
        e_gv       = 1'b0;
        e_gpc      = '0;
        e_gq       = '0;
        e_gslot    = 0;
        e_active   = 0;
        e_running  = 1'b0;
        e_none     = 1'b0;
    endtask

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            model_reset();
        end else begin
            p_save = 1'b0;
            e_none = 1'b0;
            case (m_phase)
                PH_IDLE: if (sched_req) begin
                    for (int k = 1; k <= NPROC; k++) m_probes.push_back((m_last + k) % NPROC);
                    m_phase = PH_SEARCH;
                end
                PH_SEARCH: begin
                    p_slot = m_probes.pop_front();
                    if (m_valid[p_slot]) begin
                        e_gv    = 1'b1;
                        e_gpc   = m_pc[p_slot];
                        e_gq    = m_q[p_slot];
                        e_gslot = p_slot;
                        m_probes.delete();
                        m_phase = PH_GRANT;
                    end else if (m_probes.size() == 0) begin
                        e_none  = 1'b1;
                        m_phase = PH_IDLE;
                    end
                end
                PH_GRANT: if (grant_ready) begin
                    e_gv      = 1'b0;
                    e_active  = e_gslot;
                    m_last    = e_gslot;
                    e_running = 1'b1;
                    m_phase   = PH_RUN;
                end
                PH_RUN: if (ctx_req && !m_ctx_prev) begin
                    m_spc   = saved_pc;
                    m_end   = proc_end;
                    m_phase = PH_SAVE;
                end
                PH_SAVE: begin
                    p_save    = 1'b1;
                    e_running = 1'b0;
                    m_phase   = PH_IDLE;
                end
                default: m_phase = PH_IDLE;
            endcase
            // save first so that a same-slot load overrides it completely
            if (p_save) begin
                m_pc[e_active] = m_spc;
                if (m_end) m_valid[e_active] = 1'b0;
            end
            if (load_en) begin
                m_pc[load_slot]    = load_pc;
                m_q[load_slot]     = load_quantum;
                m_valid[load_slot] = 1'b1;
            end
            m_ctx_prev = ctx_req;
        end
    end

    always @(negedge CLK) begin
        check("grant_valid", grant_valid, e_gv);
        check("running", running, e_running);
        check("none_ready", none_ready, e_none);
        if (e_gv) begin
            check("grant_slot", grant_slot, e_gslot);
            check("grant_pc", grant_pc, e_gpc);
            check("grant_quantum", grant_quantum, e_gq);
        end
        if (e_running) check("active_slot", active_slot, e_active);
    end

    // ---------------- directed helpers ----------------
    task automatic tick();
        @(posedge CLK);
        #2;
    endtask

    task automatic do_load(input int s, input logic [AW-1:0] pc, input logic [QW-1:0] q);
        load_en = 1'b1; load_slot = SW'(s); load_pc = pc; load_quantum = q;
        tick();
        load_en = 1'b0;
    endtask

    task automatic sched();
        sched_req = 1'b1;
        tick();
        sched_req = 1'b0;
    endtask

    task automatic wait_grant(output int cyc);
        cyc = 0;
        while (!grant_valid && cyc < NPROC + 2) begin
            tick();
            cyc++;
        end
        check("grant_within_bound", grant_valid, 1);
    endtask

    task automatic accept();
        grant_ready = 1'b1;
        tick();
        grant_ready = 1'b0;
    endtask

    task automatic switch_out(input logic [AW-1:0] pc, input bit fin);
        ctx_req = 1'b1; saved_pc = pc; proc_end = fin;
        tick();
        tick();
        ctx_req = 1'b0; proc_end = 1'b0;
    endtask

    task automatic expect_none(input string name);
        int  n;
        bit  saw_gv;
        n = 0; saw_gv = 1'b0;
        while (!none_ready && n < NPROC + 2) begin
            tick();
            n++;
            if (grant_valid) saw_gv = 1'b1;
        end
        check({name, "_probes"}, n, NPROC);
        check({name, "_no_grant"}, saw_gv, 0);
        tick();
        check({name, "_pulse_width"}, none_ready, 0);
    endtask

    int cyc;

    initial begin
        reset = 1'b0; ctx_req = 1'b0; saved_pc = '0; proc_end = 1'b0;
        sched_req = 1'b0; load_en = 1'b0; load_slot = '0; load_pc = '0;
        load_quantum = '0; grant_ready = 1'b0;
        tick();
        tick();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_running", running, 0);
        check("rst_none_ready", none_ready, 0);
        check("rst_active_slot", active_slot, 0);
        check("rst_grant_pc", grant_pc, 0);
        reset = 1'b1;
        tick();

        // 1: first dispatch starts at slot 0 (last_slot resets to NPROC-1)
        do_load(0, 32'h100, 32'd5);
        do_load(2, 32'h200, 32'd7);
        sched();
        wait_grant(cyc);
        check("t1_latency", cyc, 1);
        check("t1_slot", grant_slot, 0);
        check("t1_pc", grant_pc, 32'h100);
        check("t1_q", grant_quantum, 32'd5);
        accept();
        check("t1_running", running, 1);
        check("t1_active", active_slot, 0);
        check("t1_gv_drop", grant_valid, 0);

        // 2: save and round-robin
        switch_out(32'h144, 1'b0);
        check("t2_stopped", running, 0);
        sched();
        wait_grant(cyc);
        check("t2_slot", grant_slot, 2);
        check("t2_pc", grant_pc, 32'h200);
        check("t2_q", grant_quantum, 32'd7);
        accept();
        switch_out(32'h2a0, 1'b0);
        sched();
        wait_grant(cyc);
        check("t2b_slot", grant_slot, 0);
        check("t2b_pc", grant_pc, 32'h144);
        accept();

        // 3: finish both processes, then search finds nothing
        switch_out(32'h150, 1'b1);
        sched();
        wait_grant(cyc);
        check("t3_slot", grant_slot, 2);
        check("t3_pc", grant_pc, 32'h2a0);
        accept();
        switch_out(32'h2b0, 1'b1);
        sched();
        expect_none("t3");

        // 4: grant payload held while the slot is rewritten
        do_load(1, 32'h300, 32'd9);
        sched();
        wait_grant(cyc);
        check("t4_latency", cyc, 3);
        check("t4_slot", grant_slot, 1);
        for (int i = 0; i < 5; i++) begin
            load_en = 1'b1; load_slot = 2'd1; load_pc = 32'h3ff; load_quantum = 32'd11;
            tick();
            check("t4_hold_gv", grant_valid, 1);
            check("t4_hold_pc", grant_pc, 32'h300);
            check("t4_hold_q", grant_quantum, 32'd9);
        end
        load_en = 1'b0;
        accept();
        check("t4_active", active_slot, 1);

        // 5: load collides with SAVE(proc_end) on the same slot; load wins.
        //    Slot 1 is then the only valid slot and equals last_slot.
        ctx_req = 1'b1; saved_pc = 32'h155; proc_end = 1'b1;
        tick();
        load_en = 1'b1; load_slot = 2'd1; load_pc = 32'h400; load_quantum = 32'd13;
        tick();
        load_en = 1'b0; ctx_req = 1'b0; proc_end = 1'b0;
        check("t5_stopped", running, 0);
        sched();
        wait_grant(cyc);
        check("t5_final_probe", cyc, NPROC);
        check("t5_slot", grant_slot, 1);
        check("t5_pc", grant_pc, 32'h400);
        check("t5_q", grant_quantum, 32'd13);

        // 6: reset during GRANT
        reset = 1'b0;
        #1;
        check("t6_gv_async", grant_valid, 0);
        check("t6_running", running, 0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        sched();
        expect_none("t6");

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 599) != 0);
            sched_req    = ($urandom_range(0, 2) == 0);
            grant_ready  = ($urandom_range(0, 1) == 0);
            load_en      = ($urandom_range(0, 5) == 0);
            load_slot    = SW'($urandom_range(0, NPROC - 1));
            load_pc      = $urandom;
            load_quantum = $urandom;
            if ($urandom_range(0, 3) == 0) ctx_req = ~ctx_req;
            saved_pc     = $urandom;
            proc_end     = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b1;
        sched_req = 1'b0; load_en = 1'b0; grant_ready = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
